// File: rtl/float_to_fixed.sv
// Converts sign|exponent|fraction floats into saturating signed fixed-point words with Q fractional bits.
// Latency: 3 enabled cycles from input transfer to out_valid; one word per cycle when out_ready is held high.
// Backpressure: the whole pipe stalls when out_valid=1 and out_ready=0; in_ready mirrors the stage enable.
module float_to_fixed #(
    parameter int E_BIT = 5,
    parameter int F_BIT = 8,
    parameter int W     = 16,
    parameter int Q     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [E_BIT+F_BIT:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_ovf
);

    localparam int E_REF = (1 << (E_BIT - 1)) - 1;
    localparam int SH_W  = E_BIT + 2;
    localparam int M_W   = F_BIT + 1;
    localparam int X_W   = W + F_BIT + 2;

    localparam logic signed [SH_W-1:0] SH_OFF  = SH_W'(Q - F_BIT - E_REF);
    localparam logic signed [SH_W-1:0] SH_WMAX = SH_W'(W);
    localparam logic        [SH_W-1:0] N_MAX   = SH_W'(M_W);
    localparam logic [X_W-1:0] MIN_X = {{(X_W-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]   MAX_P = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   MIN_N = {1'b1, {(W-1){1'b0}}};

    // All stages advance together; a stalled output freezes the whole pipe.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic             in_s;
    logic [E_BIT-1:0] in_e;
    logic [F_BIT-1:0] in_f;
    assign {in_s, in_e, in_f} = in_data;

    logic signed [SH_W-1:0] sh_c;
    assign sh_c = $signed({2'b00, in_e}) + SH_OFF;

    logic                   s1_vld, s1_s, s1_zero, s1_spec;
    logic [M_W-1:0]         s1_m;
    logic signed [SH_W-1:0] s1_sh;

    // Stage 1: split the float, restore the hidden bit, classify and derive the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_s    <= in_s;
                s1_m    <= {1'b1, in_f};
                s1_zero <= (in_e == '0);
                s1_spec <= (&in_e);
                s1_sh   <= sh_c;
            end
        end
    end

    logic [X_W-1:0]  m_x, mag_full;
    logic [SH_W-1:0] n_c;
    logic            big_c, ovf_pre_c, min_c;

    // Stage 2 datapath: align the magnitude; right shifts round half away from zero.
    always_comb begin
        mag_full  = '0;
        ovf_pre_c = 1'b0;
        big_c     = 1'b0;
        min_c     = 1'b0;
        m_x       = X_W'(s1_m);
        n_c       = -s1_sh;
        if (!s1_sh[SH_W-1]) begin
            big_c     = (s1_sh >= SH_WMAX);
            mag_full  = m_x << $unsigned(s1_sh);
            ovf_pre_c = big_c || (|mag_full[X_W-1:W-1]);
        end else if (n_c <= N_MAX) begin
            mag_full = (m_x >> n_c) + ((m_x >> (n_c - 1'b1)) & X_W'(1));
        end
        // Exactly 2^(W-1) is still representable when the sign is negative.
        min_c = !big_c && (mag_full == MIN_X);
        if (s1_zero) begin
            mag_full  = '0;
            ovf_pre_c = 1'b0;
            min_c     = 1'b0;
        end
        if (s1_spec) begin
            ovf_pre_c = 1'b1;
            min_c     = 1'b0;
        end
    end

    logic           s2_vld, s2_s, s2_ovf, s2_min;
    logic [W-1:0]   s2_mag;

    // Stage 2 register: hold the aligned magnitude and the overflow hints.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else if (en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_s   <= s1_s;
                s2_mag <= mag_full[W-1:0];
                s2_ovf <= ovf_pre_c;
                s2_min <= min_c;
            end
        end
    end

    logic [W-1:0] res_c;
    logic         res_ovf_c;

    // Stage 3 datapath: apply the sign and saturate anything outside the signed range.
    always_comb begin
        res_c     = s2_s ? (~s2_mag + 1'b1) : s2_mag;
        res_ovf_c = 1'b0;
        if (s2_s && s2_min) begin
            res_c = MIN_N;
        end else if (s2_ovf || s2_mag[W-1]) begin
            res_c     = s2_s ? MIN_N : MAX_P;
            res_ovf_c = 1'b1;
        end
    end

    // Output register: only moves on an enabled edge so stalled data stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_data <= res_c;
                out_ovf  <= res_ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// Randomised and directed stimulus for float_to_fixed, checked against an arithmetic reference model.
// Latency: outputs are matched to inputs through an in-order scoreboard sampled on the falling edge.
// Backpressure: exercises stalls, hold stability, random out_ready and a reset with words in flight.
module tb_float_to_fixed;

    localparam int E_BIT = 5;
    localparam int F_BIT = 8;
    localparam int W     = 16;
    localparam int Q     = 8;
    localparam int E_REF = (1 << (E_BIT - 1)) - 1;

    logic                 clk;
    logic                 rst;
    logic [E_BIT+F_BIT:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_ovf;

    int n_chk = 0;
    int n_err = 0;
    logic [W:0] sb[$];
    bit rand_done;

    float_to_fixed #(.E_BIT(E_BIT), .F_BIT(F_BIT), .W(W), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Value = (-1)^s * (1 + f/2^F) * 2^(e-bias), scaled by 2^Q, rounded half away from zero, saturated.
    function automatic logic [W:0] model(input logic [E_BIT+F_BIT:0] w);
        logic s;
        int e, k;
        longint m, mag, lim;
        s   = w[E_BIT+F_BIT];
        e   = int'(w[E_BIT+F_BIT-1:F_BIT]);
        m   = longint'(w[F_BIT-1:0]) + (longint'(1) << F_BIT);
        lim = longint'(1) << (W - 1);
        if (e == 0) return '0;
        if (e == (1 << E_BIT) - 1) return {1'b1, s ? lim[W-1:0] : W'(lim - 1)};
        k = e - E_REF + Q - F_BIT;
        if (k >= 0) mag = m << k;
        else mag = (m + (longint'(1) << (-k - 1))) >> (-k);
        if (s && mag == lim) return {1'b0, lim[W-1:0]};
        if (mag > lim - 1) return {1'b1, s ? lim[W-1:0] : W'(lim - 1)};
        if (s) mag = -mag;
        return {1'b0, mag[W-1:0]};
    endfunction

    // Scoreboard: record accepted inputs, match every output transfer in order.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check_eq("data", 32'(out_data), 32'(exp[W-1:0]));
                    check_eq("ovf", 32'(out_ovf), 32'(exp[W]));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
        end
    end

    task automatic send(input logic [E_BIT+F_BIT:0] w);
        int t;
        t = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [E_BIT+F_BIT:0] mk(input logic s, input int e, input int f);
        return {s, E_BIT'(e), F_BIT'(f)};
    endfunction

    initial begin
        logic [E_BIT+F_BIT:0] dir[$];
        int cnt;
        int t;
        rand_done = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        idle(1);

        // Latency of a single word.
        send(14'h0F00);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq("latency", 32'(cnt), 32'd3);
        check_eq("one_data", 32'(out_data), 32'h0100);
        idle(4);

        // Directed corner values streamed back-to-back.
        dir = '{14'h3040, mk(0,6,8'h00), mk(1,6,8'h00), mk(0,5,8'hFF), mk(0,6,8'hFF),
                mk(0,22,0), mk(1,22,0), mk(1,22,8'h80), mk(0,31,8'h5A), mk(1,31,0),
                14'h0000, mk(0,0,8'hA5), 14'h2000, mk(0,21,8'hFF), mk(1,21,8'hFF)};
        foreach (dir[i]) send(dir[i]);
        idle(6);
        check_eq("dir_drain", 32'(sb.size()), 32'd0);

        // Backpressure: stall after the first word, check hold, then release.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(mk(i[0], 14 + i, 16 * i + 3));
                    if (i == 0) out_ready = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("bp_valid", 32'(out_valid), 32'd1);
                repeat (6) begin
                    @(negedge clk);
                    check_eq("bp_hold", 32'(out_data), 32'(sb[0][W-1:0]));
                    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);
        check_eq("bp_drain", 32'(sb.size()), 32'd0);

        // Random words with random bubbles and random downstream stalls.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) != 0) send(14'($urandom));
                    else idle(1);
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(10);
        check_eq("rand_drain", 32'(sb.size()), 32'd0);

        // Reset with three words in flight: none may ever emerge.
        for (int i = 0; i < 3; i++) send(mk(0, 15 + i, 8'h11));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        check_eq("mid_rst_ovf", 32'(out_ovf), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(8);
        check_eq("post_rst_idle", 32'(out_valid), 32'd0);
        send(14'h0F00);
        idle(6);
        check_eq("post_rst_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/float_to_fixed.md
Name: float_to_fixed

Overview:
- Pipelined decoder that converts the team's custom float format into a signed two's-complement fixed-point word.
- The float format is sign | exponent (E_BIT bits, bias 2^(E_BIT-1)-1) | fraction (F_BIT bits, hidden leading 1).
- Sits at the output end of the NN datapath. It turns float adder/accumulator results into fixed-point values for activation LUTs, quantised memories and host readback.
- Uses a ready/valid stream with backpressure.

Parameters:
- E_BIT, 5, exponent width; bias E_REF = 2^(E_BIT-1)-1 (15 at default).
- F_BIT, 8, fraction width without the hidden bit.
- W, 16, output fixed-point width, two's complement.
- Q, 8, number of fractional bits in the output.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  E_BIT+F_BIT+1  float word: [MSB]=sign, [E_BIT+F_BIT-1:F_BIT]=exponent, [F_BIT-1:0]=fraction.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  W  fixed-point result, Q fractional bits.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_ovf  out  1  result saturated: magnitude out of range, or exponent = all ones.

Behaviour:
- Reset: synchronous, active-high, only clock is clk. While rst=1 at a clock edge, the following are cleared to 0: all stage valid bits, out_valid, out_data and out_ovf.
- Reset mid-operation discards every in-flight word. in_ready follows its formula and therefore reads 1 after reset.
- Pipeline enable: en = !out_valid | out_ready.
- in_ready = en, a combinational output.
- A transfer occurs on in_valid & in_ready. All three stages advance together when en=1 and hold when en=0. Bubbles are not compressed.
- Latency: 3 enabled cycles from input transfer to out_valid. Throughput is 1 word per cycle when out_ready=1.
- S1 (decode):
  - Register the sign s, exponent e and mantissa m = {1, fraction} (F_BIT+1 bits).
  - Classify: zero if e==0 (fraction ignored; flush, no denormals). Special if e == all ones (inf/overflow marker).
  - Compute signed shift sh = e - E_REF + Q - F_BIT, sized with 2 guard bits over E_BIT.
- S2 (shift/round, on magnitude):
  - If sh>=0: mag = m << sh, computed in W+F_BIT+2 bits. Set ovf_pre if any bit at or above position W-1 would be set, or if sh >= W.
  - If sh<0: mag = (m >> -sh) + bit(-sh-1) of m. This is round half away from zero, applied to the magnitude.
  - If -sh > F_BIT+1, mag = 0.
  - Zero class forces mag=0 and ovf_pre=0. Special class forces ovf_pre=1.
- S3 (sign/saturate):
  - If ovf_pre, or if mag > 2^(W-1)-1 (rounding carry included): out_data = s ? 2^(W-1) (most negative) : 2^(W-1)-1. out_ovf=1.
  - Exception: a negative value with mag == 2^(W-1) gives out_data = 2^(W-1) with out_ovf=0.
  - Otherwise out_data = s ? -mag : mag, out_ovf=0.
  - Negative zero yields 0.
- Output stability: out_data and out_ovf change only on an enabled edge. While out_valid=1 and out_ready=0 they hold stable.
- Simultaneous events:
  - out_ready=1 with a full pipe and in_valid=1: output and input transfer in the same cycle.
  - in_valid=0 inserts a bubble.

Test Plan (default parameters; in_data 14 bits = s | e[4:0] | f[7:0]):
- Basic values, out_ready=1:
  - 14'h0F00 (+1.0) -> out_data 16'h0100, out_ovf 0, out_valid exactly 3 cycles after the transfer.
  - 14'h3040 (-2.5) -> out_data 16'hFD80 (-640), out_ovf 0.
- Rounding:
  - e=6, f=8'h00 (0.5 LSB) -> 16'h0001.
  - Same with sign=1 -> 16'hFFFF.
  - e=5, f=8'hFF (0.499 LSB) -> 16'h0000.
  - e=6, f=8'hFF -> 16'h0001.
- Saturation:
  - e=22, f=0 (+128.0) -> 16'h7FFF, out_ovf 1.
  - Same with sign=1 (-128.0) -> 16'h8000, out_ovf 0.
  - e=22, f=8'h80, sign=1 -> 16'h8000, out_ovf 1.
  - e=31, any fraction -> saturates by sign, out_ovf 1.
- Zero/flush:
  - 14'h0000 -> 0.
  - e=0, f=8'hA5 -> 0, out_ovf 0.
  - 14'h2000 (-0) -> 16'h0000.
- Backpressure:
  - Stream 5 words back-to-back with out_ready held 0 from cycle 2. in_ready drops once out_valid=1.
  - out_data holds the first result unchanged.
  - Release out_ready -> all 5 results appear in order, none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 words in flight -> the next edge shows out_valid 0, out_data 0, out_ovf 0, in_ready 1, and none of the 3 words ever emerge.
